// File: rtl/minx_pkg.sv
// Shared minx definitions: CPU bus_status encodings and the bus arbiter state enum.
package minx_pkg;

    localparam logic [1:0] BUS_COMMAND_IDLE      = 2'd0;
    localparam logic [1:0] BUS_COMMAND_IRQ_READ  = 2'd1;
    localparam logic [1:0] BUS_COMMAND_MEM_WRITE = 2'd2;
    localparam logic [1:0] BUS_COMMAND_MEM_READ  = 2'd3;

    typedef enum logic [1:0] {
        ARB_CPU,
        ARB_REQ,
        ARB_DMA,
        ARB_REL
    } arb_state_t;

endpackage

// File: rtl/minx_bus_arbiter_if.sv
// Secondary bus master port: burst request/grant plus the single-byte access handshake.
interface minx_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 24
);

    logic                  dma_req;
    logic                  dma_gnt;
    logic                  dma_valid;
    logic                  dma_ready;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_address;
    logic [7:0]            dma_wdata;
    logic                  dma_rvalid;

    modport master (
        output dma_req, dma_valid, dma_we, dma_address, dma_wdata,
        input  dma_gnt, dma_ready, dma_rvalid
    );

    modport slave (
        input  dma_req, dma_valid, dma_we, dma_address, dma_wdata,
        output dma_gnt, dma_ready, dma_rvalid
    );

endinterface

// File: rtl/minx_bus_arbiter.sv
// Parks the minx CPU via bus_request/bus_ack and lends the memory bus to one secondary master.
// Optional acknowledge timeout: define MINX_BUS_ARB_TIMEOUT_EN.
module minx_bus_arbiter
    import minx_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]            cpu_data,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_bus_status,
    output logic                  bus_request,
    input  logic                  bus_ack,
    minx_bus_arbiter_if.slave     dma,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic [1:0]            mem_bus_status,
    output logic                  timeout_err
);

    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be in 1..65535");
    end

    arb_state_t state, state_nxt;
    logic       ack_expired;
    logic       retry_block;
    logic       accept;
    logic       dma_owner;
    logic       rd_pend;

`ifdef MINX_BUS_ARB_TIMEOUT_EN
    logic [15:0] ack_cnt;

    assign ack_expired = (state == ARB_REQ) && !bus_ack && (ack_cnt == 16'(ACK_TIMEOUT - 1));

    // After a timeout the master must drop dma_req before it may try again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_cnt     <= '0;
            retry_block <= 1'b0;
        end else begin
            ack_cnt <= (state == ARB_REQ) ? ack_cnt + 16'd1 : 16'd0;
            if (ack_expired)
                retry_block <= 1'b1;
            else if (!dma.dma_req)
                retry_block <= 1'b0;
        end
    end
`else
    assign ack_expired = 1'b0;
    assign retry_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARB_CPU;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= accept && !dma.dma_we;
        end
    end

    always_comb begin
        state_nxt      = state;
        dma_owner      = (state == ARB_DMA) || (state == ARB_REL);
        bus_request    = (state == ARB_REQ) || (state == ARB_DMA);
        dma.dma_gnt    = (state == ARB_DMA);
        // A DMA cycle with dma_req low is the exit cycle (or the leftover of an
        // abandoned request): nothing is accepted in it.
        dma.dma_ready  = (state == ARB_DMA) && dma.dma_req;
        accept         = dma.dma_valid && dma.dma_ready;
        dma.dma_rvalid = rd_pend;
        timeout_err    = ack_expired;

        case (state)
            ARB_CPU: if (dma.dma_req && !retry_block) state_nxt = ARB_REQ;
            ARB_REQ: begin
                if (bus_ack)
                    state_nxt = ARB_DMA;
                else if (ack_expired)
                    state_nxt = ARB_CPU;
            end
            ARB_DMA: if (!dma.dma_req) state_nxt = ARB_REL;
            ARB_REL: if (!bus_ack) state_nxt = ARB_CPU;
            default: state_nxt = ARB_CPU;
        endcase

        if (dma_owner) begin
            mem_address    = dma.dma_address;
            mem_data       = dma.dma_wdata;
            mem_we         = accept && dma.dma_we;
            mem_bus_status = !accept     ? BUS_COMMAND_IDLE :
                             dma.dma_we  ? BUS_COMMAND_MEM_WRITE : BUS_COMMAND_MEM_READ;
        end else begin
            mem_address    = cpu_address;
            mem_data       = cpu_data;
            mem_we         = cpu_we;
            mem_bus_status = cpu_bus_status;
        end
    end

endmodule

// File: tb/tb_minx_bus_arbiter.sv
// Scenario bench for minx_bus_arbiter; write/read expectations travel through scoreboard queues.
module tb_minx_bus_arbiter;
    import minx_pkg::*;

    localparam int AW = 24;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [7:0]    cpu_data = '0;
    logic          cpu_we = 1'b0;
    logic [1:0]    cpu_bus_status = BUS_COMMAND_IDLE;
    logic          bus_request;
    logic          bus_ack = 1'b0;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic [1:0]    mem_bus_status;
    logic          timeout_err;

    minx_bus_arbiter_if #(.ADDR_WIDTH(AW)) dma_bus ();

    minx_bus_arbiter #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_we(cpu_we),
        .cpu_bus_status(cpu_bus_status),
        .bus_request(bus_request), .bus_ack(bus_ack),
        .dma(dma_bus.slave),
        .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we),
        .mem_bus_status(mem_bus_status), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    int            n_pass = 0;
    int            n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        wr_t e;
        dma_bus.dma_req = 1'b0; dma_bus.dma_valid = 1'b0; dma_bus.dma_we = 1'b0;
        dma_bus.dma_address = '0; dma_bus.dma_wdata = '0;
        cpu_we = 1'b1; cpu_address = 24'h000123; cpu_data = 8'h77;
        cpu_bus_status = BUS_COMMAND_MEM_WRITE;
        wq.push_back('{24'h000123, 8'h77});
        #3;
        n_total++; if (bus_request !== 1'b0) $display("FAIL reset_bus_request: got %b want 0", bus_request); else n_pass++;
        n_total++; if (dma_bus.dma_gnt !== 1'b0) $display("FAIL reset_dma_gnt: got %b want 0", dma_bus.dma_gnt); else n_pass++;
        n_total++; if (dma_bus.dma_ready !== 1'b0) $display("FAIL reset_dma_ready: got %b want 0", dma_bus.dma_ready); else n_pass++;
        n_total++; if (dma_bus.dma_rvalid !== 1'b0) $display("FAIL reset_dma_rvalid: got %b want 0", dma_bus.dma_rvalid); else n_pass++;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_total++;
        if (mem_we !== 1'b1 || wq.size() == 0) $display("FAIL reset_mem_we: got %b want 1", mem_we);
        else begin
            e = wq.pop_front(); n_pass++;
            n_total++; if (mem_address !== e.addr) $display("FAIL reset_mem_address: got %h want %h", mem_address, e.addr); else n_pass++;
        end
        cpu_we = 1'b0; cpu_bus_status = BUS_COMMAND_IDLE;
        #1;
        n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we_follow: got %b want 0", mem_we); else n_pass++;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        wr_t e;
        tick();
        cpu_address = 24'h001400; cpu_data = 8'h5A; cpu_we = 1'b1;
        cpu_bus_status = BUS_COMMAND_MEM_WRITE;
        wq.push_back('{24'h001400, 8'h5A});
        sample();
        n_total++; if (bus_request !== 1'b0) $display("FAIL idle_bus_request: got %b want 0", bus_request); else n_pass++;
        n_total++; if (mem_bus_status !== BUS_COMMAND_MEM_WRITE) $display("FAIL idle_status: got %h want %h", mem_bus_status, BUS_COMMAND_MEM_WRITE); else n_pass++;
        n_total++;
        if (mem_we !== 1'b1 || wq.size() == 0) $display("FAIL idle_mem_we: got %b want 1", mem_we);
        else begin
            e = wq.pop_front(); n_pass++;
            n_total++; if (mem_address !== e.addr) $display("FAIL idle_addr: got %h want %h", mem_address, e.addr); else n_pass++;
            n_total++; if (mem_data !== e.data) $display("FAIL idle_data: got %h want %h", mem_data, e.data); else n_pass++;
        end
        tick();
        cpu_we = 1'b0; cpu_bus_status = BUS_COMMAND_IDLE;
    endtask

    task automatic test_grant();
        tick();
        dma_bus.dma_req = 1'b1;
        sample();
        n_total++; if (bus_request !== 1'b0) $display("FAIL grant_req_latency: got %b want 0", bus_request); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick(); sample();
            n_total++; if (bus_request !== 1'b1 || dma_bus.dma_gnt !== 1'b0) $display("FAIL grant_req_wait%0d: got req=%b gnt=%b want req=1 gnt=0", i, bus_request, dma_bus.dma_gnt); else n_pass++;
        end
        tick();
        bus_ack = 1'b1;
        sample();
        n_total++; if (dma_bus.dma_gnt !== 1'b0) $display("FAIL grant_early: got gnt=%b want 0", dma_bus.dma_gnt); else n_pass++;
        tick();
        cpu_we = 1'b1; cpu_address = 24'h003333; cpu_bus_status = BUS_COMMAND_MEM_WRITE;
        sample();
        n_total++; if (dma_bus.dma_gnt !== 1'b1) $display("FAIL grant_gnt: got %b want 1", dma_bus.dma_gnt); else n_pass++;
        n_total++; if (dma_bus.dma_ready !== 1'b1) $display("FAIL grant_ready: got %b want 1", dma_bus.dma_ready); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL grant_cpu_blocked: got mem_we=%b want 0", mem_we); else n_pass++;
        n_total++; if (bus_request !== 1'b1) $display("FAIL grant_req_hold: got %b want 1", bus_request); else n_pass++;
        cpu_we = 1'b0; cpu_bus_status = BUS_COMMAND_IDLE;
    endtask

    task automatic test_burst();
        wr_t           e;
        logic [AW-1:0] acc_addr;
        for (int i = 0; i < 4; i++) begin
            tick();
            dma_bus.dma_valid = 1'b1; dma_bus.dma_we = 1'b1;
            dma_bus.dma_address = 24'h001000 + AW'(i); dma_bus.dma_wdata = 8'h11 + 8'(i);
            wq.push_back('{24'h001000 + AW'(i), 8'h11 + 8'(i)});
            sample();
            n_total++;
            if (mem_we !== 1'b1 || wq.size() == 0) $display("FAIL burst_we%0d: got %b want 1", i, mem_we);
            else begin
                e = wq.pop_front(); n_pass++;
                n_total++; if (mem_address !== e.addr) $display("FAIL burst_addr%0d: got %h want %h", i, mem_address, e.addr); else n_pass++;
                n_total++; if (mem_data !== e.data) $display("FAIL burst_data%0d: got %h want %h", i, mem_data, e.data); else n_pass++;
            end
            n_total++; if (mem_bus_status !== BUS_COMMAND_MEM_WRITE) $display("FAIL burst_status%0d: got %h want %h", i, mem_bus_status, BUS_COMMAND_MEM_WRITE); else n_pass++;
            n_total++; if (dma_bus.dma_rvalid !== 1'b0) $display("FAIL burst_rvalid%0d: got %b want 0", i, dma_bus.dma_rvalid); else n_pass++;
        end
        tick();
        dma_bus.dma_we = 1'b0; dma_bus.dma_address = 24'h001001;
        rq.push_back(24'h001001);
        sample();
        acc_addr = mem_address;
        n_total++; if (mem_we !== 1'b0) $display("FAIL read_mem_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (mem_bus_status !== BUS_COMMAND_MEM_READ) $display("FAIL read_status: got %h want %h", mem_bus_status, BUS_COMMAND_MEM_READ); else n_pass++;
        n_total++; if (dma_bus.dma_rvalid !== 1'b0) $display("FAIL read_rvalid_early: got %b want 0", dma_bus.dma_rvalid); else n_pass++;
        tick();
        dma_bus.dma_valid = 1'b0;
        sample();
        n_total++;
        if (dma_bus.dma_rvalid !== 1'b1 || rq.size() == 0) $display("FAIL read_rvalid: got %b want 1", dma_bus.dma_rvalid);
        else begin
            n_pass++;
            n_total++; if (acc_addr !== rq[0]) $display("FAIL read_addr: got %h want %h", acc_addr, rq[0]); else n_pass++;
            void'(rq.pop_front());
        end
        tick(); sample();
        n_total++; if (dma_bus.dma_rvalid !== 1'b0) $display("FAIL read_rvalid_once: got %b want 0", dma_bus.dma_rvalid); else n_pass++;
    endtask

    task automatic test_release();
        wr_t e;
        tick();
        dma_bus.dma_req = 1'b0; dma_bus.dma_valid = 1'b1; dma_bus.dma_we = 1'b1;
        dma_bus.dma_address = 24'h001FFF; dma_bus.dma_wdata = 8'hEE;
        sample();
        n_total++; if (dma_bus.dma_ready !== 1'b0 || mem_we !== 1'b0) $display("FAIL rel_exit_ignored: got ready=%b we=%b want 0 0", dma_bus.dma_ready, mem_we); else n_pass++;
        n_total++; if (bus_request !== 1'b1) $display("FAIL rel_exit_req: got %b want 1", bus_request); else n_pass++;
        tick(); sample();
        n_total++; if (bus_request !== 1'b0 || dma_bus.dma_gnt !== 1'b0) $display("FAIL rel_drop: got req=%b gnt=%b want 0 0", bus_request, dma_bus.dma_gnt); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rel_we0: got %b want 0", mem_we); else n_pass++;
        tick();
        bus_ack = 1'b0;
        cpu_we = 1'b1; cpu_address = 24'h002000; cpu_data = 8'hA5; cpu_bus_status = BUS_COMMAND_MEM_WRITE;
        sample();
        n_total++; if (mem_we !== 1'b0) $display("FAIL rel_we1: got %b want 0", mem_we); else n_pass++;
        n_total++; if (mem_address !== 24'h001FFF) $display("FAIL rel_owner: got %h want 001fff", mem_address); else n_pass++;
        tick();
        wq.push_back('{24'h002000, 8'hA5});
        sample();
        n_total++;
        if (mem_we !== 1'b1 || wq.size() == 0) $display("FAIL rel_cpu_we: got %b want 1", mem_we);
        else begin
            e = wq.pop_front(); n_pass++;
            n_total++; if (mem_address !== e.addr || mem_data !== e.data) $display("FAIL rel_cpu_bus: got %h/%h want %h/%h", mem_address, mem_data, e.addr, e.data); else n_pass++;
        end
        tick();
        cpu_we = 1'b0; cpu_bus_status = BUS_COMMAND_IDLE; dma_bus.dma_valid = 1'b0;
    endtask

    task automatic test_req_drop();
        tick();
        dma_bus.dma_req = 1'b1;
        tick();
        tick();
        dma_bus.dma_req = 1'b0; dma_bus.dma_valid = 1'b1; dma_bus.dma_we = 1'b1;
        sample();
        n_total++; if (bus_request !== 1'b1 || dma_bus.dma_gnt !== 1'b0) $display("FAIL drop_wait: got req=%b gnt=%b want 1 0", bus_request, dma_bus.dma_gnt); else n_pass++;
        tick();
        bus_ack = 1'b1;
        sample();
        n_total++; if (bus_request !== 1'b1) $display("FAIL drop_wait_ack: got %b want 1", bus_request); else n_pass++;
        tick(); sample();
        n_total++; if (dma_bus.dma_gnt !== 1'b1 || dma_bus.dma_ready !== 1'b0 || mem_we !== 1'b0) $display("FAIL drop_pass: got gnt=%b ready=%b we=%b want 1 0 0", dma_bus.dma_gnt, dma_bus.dma_ready, mem_we); else n_pass++;
        tick();
        bus_ack = 1'b0;
        sample();
        n_total++; if (bus_request !== 1'b0 || dma_bus.dma_gnt !== 1'b0) $display("FAIL drop_rel: got req=%b gnt=%b want 0 0", bus_request, dma_bus.dma_gnt); else n_pass++;
        tick();
        dma_bus.dma_valid = 1'b0;
        cpu_address = 24'h000456;
        sample();
        n_total++; if (mem_address !== 24'h000456) $display("FAIL drop_cpu_back: got %h want 000456", mem_address); else n_pass++;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int to_pulses = 0;
        tick();
        dma_bus.dma_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); sample();
            if (bus_request === 1'b1) req_cycles++;
            if (timeout_err === 1'b1) to_pulses++;
        end
`ifdef MINX_BUS_ARB_TIMEOUT_EN
        n_total++; if (req_cycles !== TO) $display("FAIL to_req_cycles: got %0d want %0d", req_cycles, TO); else n_pass++;
        n_total++; if (to_pulses !== 1) $display("FAIL to_pulses: got %0d want 1", to_pulses); else n_pass++;
        n_total++; if (bus_request !== 1'b0) $display("FAIL to_blocked: got %b want 0", bus_request); else n_pass++;
        tick();
        dma_bus.dma_req = 1'b0;
        tick();
        dma_bus.dma_req = 1'b1;
        tick(); sample();
        n_total++; if (bus_request !== 1'b1) $display("FAIL to_retry: got %b want 1", bus_request); else n_pass++;
`else
        n_total++; if (req_cycles !== 20) $display("FAIL noto_req_cycles: got %0d want 20", req_cycles); else n_pass++;
        n_total++; if (to_pulses !== 0) $display("FAIL noto_pulses: got %0d want 0", to_pulses); else n_pass++;
`endif
        tick();
        bus_ack = 1'b1;
        tick();
        dma_bus.dma_req = 1'b0;
        tick();
        bus_ack = 1'b0;
        tick(); sample();
        n_total++; if (bus_request !== 1'b0 || dma_bus.dma_gnt !== 1'b0) $display("FAIL to_cleanup: got req=%b gnt=%b want 0 0", bus_request, dma_bus.dma_gnt); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        tick();
        dma_bus.dma_req = 1'b1;
        tick();
        bus_ack = 1'b1;
        tick();
        dma_bus.dma_valid = 1'b1; dma_bus.dma_we = 1'b0; dma_bus.dma_address = 24'h001002;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (bus_request !== 1'b0) $display("FAIL rst_bus_request: got %b want 0", bus_request); else n_pass++;
        n_total++; if (dma_bus.dma_gnt !== 1'b0) $display("FAIL rst_dma_gnt: got %b want 0", dma_bus.dma_gnt); else n_pass++;
        n_total++; if (dma_bus.dma_ready !== 1'b0) $display("FAIL rst_dma_ready: got %b want 0", dma_bus.dma_ready); else n_pass++;
        dma_bus.dma_req = 1'b0; dma_bus.dma_valid = 1'b0; bus_ack = 1'b0;
        tick(); sample();
        n_total++; if (dma_bus.dma_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", dma_bus.dma_rvalid); else n_pass++;
        tick();
        reset_n = 1'b1;
        cpu_address = 24'h000ABC;
        tick(); sample();
        n_total++; if (mem_address !== 24'h000ABC || bus_request !== 1'b0) $display("FAIL rst_cpu_state: got addr=%h req=%b want 000abc 0", mem_address, bus_request); else n_pass++;
        n_total++; if (dma_bus.dma_rvalid !== 1'b0) $display("FAIL rst_rvalid_after: got %b want 0", dma_bus.dma_rvalid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_grant();
        test_burst();
        test_release();
        test_req_drop();
        test_timeout();
        test_reset_mid_burst();
        n_total++;
        if (wq.size() != 0 || rq.size() != 0) $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", wq.size(), rq.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/minx_bus_arbiter.md
# minx_bus_arbiter

Shares the single system memory bus (BIOS/RAM/framebuffer address space) between the minx CPU and one secondary bus master (cartridge loader or LCD GDRAM copy engine). It uses the CPU's bus_request/bus_ack hold handshake to park the CPU, grants the bus to the secondary master for a burst of single-byte accesses, then returns ownership. It sits between minx, the DMA master and the memory decode/mux logic in emu.

## Interface
- `ADDR_WIDTH`, 24: bus address width.
- `ACK_TIMEOUT`, 255: maximum cycles spent in REQ waiting for bus_ack (only used with timeout enabled); 1..65535.
- `clk` in 1: system clock (clk_sys). Single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cpu_address` in ADDR_WIDTH: CPU address_out.
- `cpu_data` in 8: CPU data_out.
- `cpu_we` in 1: CPU write strobe.
- `cpu_bus_status` in 2: CPU bus_status.
- `bus_request` out 1: hold request to CPU.
- `bus_ack` in 1: CPU hold acknowledge (CPU bus released).
- `dma_req` in 1: secondary master wants the bus; level, held for the whole burst.
- `dma_gnt` out 1: secondary master owns the bus.
- `dma_valid` in 1: access presented this cycle.
- `dma_ready` out 1: access accepted when valid && ready.
- `dma_we` in 1: 1 = write, 0 = read.
- `dma_address` in ADDR_WIDTH, `dma_wdata` in 8: access address/data.
- `dma_rvalid` out 1: read data on mem_q is valid for the DMA master.
- `mem_address` out ADDR_WIDTH, `mem_data` out 8, `mem_we` out 1: to memory decode.
- `mem_bus_status` out 2: bus status seen by decode (MEM_WRITE for DMA writes, MEM_READ for DMA reads).
- `timeout_err` out 1: one-cycle pulse on acknowledge timeout.

## Operation
- FSM states: CPU, REQ, DMA, REL. Reset state CPU.
- CPU: memory outputs mirror the cpu_* inputs combinationally. If dma_req is high, go to REQ.
- REQ: assert bus_request; outputs still mirror the CPU. When bus_ack is sampled high, go to DMA.
- DMA: dma_gnt=1 and dma_ready=1. mem_* is driven from the dma_* inputs, with mem_we = dma_valid & dma_we. When dma_req is low, go to REL; any dma_valid in that cycle is ignored (dma_ready=0).
- REL: bus_request=0, dma_gnt=0, and mem_we forced to 0. When bus_ack is sampled low, go to CPU.
- dma_rvalid goes high exactly 1 cycle after an accepted read, matching the synchronous spram/dpram read latency.
- Owner select and the FSM state are registered; the address/data mux is combinational from the registered state.
- If dma_req drops in REQ before bus_ack arrives, keep waiting for bus_ack, then pass through DMA for one cycle with dma_ready=0, then go to REL. This avoids abandoning a half-completed handshake.
- A new dma_req during REL is honoured only after returning to CPU, so the CPU gets at least 1 cycle of ownership.
- An asynchronous reset mid-burst forces state CPU and drops bus_request immediately. Any in-flight access is lost, and no dma_rvalid is issued.

## Timing
- Reset values: bus_request=0, dma_gnt=0, dma_ready=0, dma_rvalid=0, timeout_err=0, mem_we=cpu_we (CPU owner).
- First DMA access is accepted 1 cycle after bus_ack is sampled high, which is at least 2 cycles after dma_req rises.
- Throughput is 1 access per cycle while in DMA.
- The CPU regains the bus 1 cycle after bus_ack is sampled low in REL.
- bus_request must stay high continuously from REQ entry until REL entry.

## Configuration
- `MINX_BUS_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in REQ.
  - If bus_ack is not seen within ACK_TIMEOUT cycles: pulse timeout_err, drop bus_request, return to CPU.
  - dma_req must then be deasserted and reasserted to retry.
- Not defined: REQ waits indefinitely, timeout_err is tied 0, and the counter is not built.

## Structure
- Shared package `minx_pkg`:
  - BUS_COMMAND_* status encodings (MEM_READ, MEM_WRITE).
  - The arbiter state enum.
- No sub-module; the timeout counter is inline, under the macro.

## Test plan
- Idle: dma_req=0, CPU writes 0x5A to 0x1400 → mem_address=0x1400, mem_data=0x5A, mem_we=1 in the same cycle; bus_request stays 0.
- Grant: dma_req=1, bus_ack rises 3 cycles later → dma_gnt=1 and dma_ready=1 on the next cycle; a CPU write presented during DMA does not reach mem_we.
- Burst: 4 DMA writes 0x11..0x14 to 0x1000..0x1003 on consecutive cycles → 4 consecutive mem_we pulses with matching address/data. A read of 0x1001 → dma_rvalid 1 cycle later.
- Release: drop dma_req; bus_ack falls 2 cycles later → bus_request low immediately; owner returns to CPU 1 cycle after bus_ack low; no mem_we during REL.
- Timeout (macro on, ACK_TIMEOUT=8): dma_req=1 with bus_ack held low → timeout_err pulses once, bus_request drops after 8 cycles, state returns to CPU. With the macro off, bus_request stays high indefinitely.
- Reset: assert reset_n=0 mid-burst → bus_request, dma_gnt and dma_ready go 0 asynchronously; after release, the state is CPU.
